dpram_burst_arbiter: RTL and testbench

- Shares one port of the burst dual-port RAM between two requesters (R0, R1).
- Arbitration is round-robin and non-preemptive: once granted, a burst of 1..MAX_BURST_LEN beats runs to completion.
- Drives the RAM port in single-word mode (burst_en tied low), generating every beat address itself.
- Routes write data from the owning requester to the RAM, and returns read data with a per-requester valid after a fixed RAM read latency.

---
 rtl/dpram_burst_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_dpram_burst_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_burst_arbiter.sv
// Purpose : round-robin, non-preemptive arbiter sharing one single-word RAM
//           port between two burst requesters (R0, R1).
// Latency : req -> gnt 1 cycle (IDLE -> GRANT); first beat the cycle after gnt;
//           read data returns RD_LAT cycles after its beat address.
// Backpressure: none inside a burst; a requester simply waits (req held) until
//           gnt. Bursts start at most every len+3 cycles.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   reqX/weX/addrX/lenX     burst request and parameters (sampled with gntX)
//   wdataX                  write data for the current beat (consumed on wbeatX)
//   gntX, wbeatX, doneX     grant pulse, write-beat strobe, burst-complete pulse
//   rdata, rvalidX          shared read return data, per-requester valid
//   busy                    high in GRANT or BURST
//   mem_we/addr/din/dout    single-word RAM port
module dpram_burst_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int MAX_BURST_LEN = 4,
  parameter int RD_LAT        = 2,
  localparam int LEN_W = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [LEN_W-1:0]      len0,
  input  logic [LEN_W-1:0]      len1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  wbeat0,
  output logic                  wbeat1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic                  done0,
  output logic                  done1,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST} state_t;

  state_t                state_q, state_d;
  logic                  ptr_q, ptr_d;       // 0: R0 has priority on a tie
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      beat_q, beat_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic [1:0]            wdone_q, wdone_d;   // per-requester write-complete pulse

  // Read-tag shift pipeline: bit 0 is the newest entry, bit RD_LAT-1 lines up
  // with mem_dout for the beat that pushed it.
  logic [RD_LAT-1:0]     tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0]     tag_own_q, tag_own_d;
  logic [RD_LAT-1:0]     tag_last_q, tag_last_d;

  logic                  push_vld;
  logic                  push_last;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] owner_wdata;
  logic                  out_vld;
  logic                  out_own;
  logic                  out_last;

  assign beat_addr   = base_q + ADDR_WIDTH'(beat_q);   // wraps modulo 2^ADDR_WIDTH
  assign owner_wdata = owner_q ? wdata1 : wdata0;
  assign last_beat   = (beat_q == len_q);
  assign out_vld     = tag_vld_q[RD_LAT-1];
  assign out_own     = tag_own_q[RD_LAT-1];
  assign out_last    = tag_last_q[RD_LAT-1];
  assign rdata       = mem_dout;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    we_d       = we_q;
    base_d     = base_q;
    len_d      = len_q;
    beat_d     = beat_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    wdone_d    = 2'b00;
    push_vld   = 1'b0;
    push_last  = 1'b0;

    gnt0     = 1'b0;
    gnt1     = 1'b0;
    wbeat0   = 1'b0;
    wbeat1   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = mem_addr_q;
    mem_din  = mem_din_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Tie goes to the pointer; a lone request wins outright.
          owner_d = (req0 && req1) ? ptr_q : req1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        gnt0    = ~owner_q;
        gnt1    = owner_q;
        we_d    = owner_q ? we1 : we0;
        base_d  = owner_q ? addr1 : addr0;
        len_d   = owner_q ? len1 : len0;
        beat_d  = '0;
        ptr_d   = ~owner_q;
        state_d = S_BURST;
      end
      S_BURST: begin
        mem_we     = we_q;
        mem_addr   = beat_addr;
        mem_din    = owner_wdata;
        mem_addr_d = beat_addr;
        mem_din_d  = owner_wdata;
        wbeat0     = we_q & ~owner_q;
        wbeat1     = we_q & owner_q;
        push_vld   = ~we_q;
        push_last  = last_beat;
        if (last_beat) begin
          state_d = S_IDLE;
          if (we_q) wdone_d[owner_q] = 1'b1;
        end else begin
          beat_d = beat_q + LEN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    tag_vld_d  = (tag_vld_q << 1)  | RD_LAT'(push_vld);
    tag_own_d  = (tag_own_q << 1)  | RD_LAT'(owner_q & push_vld);
    tag_last_d = (tag_last_q << 1) | RD_LAT'(push_last & push_vld);
  end

  assign busy    = (state_q != S_IDLE);
  assign rvalid0 = out_vld & ~out_own;
  assign rvalid1 = out_vld & out_own;
  assign done0   = wdone_q[0] | (rvalid0 & out_last);
  assign done1   = wdone_q[1] | (rvalid1 & out_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      wdone_q    <= 2'b00;
      tag_vld_q  <= '0;
      tag_own_q  <= '0;
      tag_last_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      base_q     <= base_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      wdone_q    <= wdone_d;
      tag_vld_q  <= tag_vld_d;
      tag_own_q  <= tag_own_d;
      tag_last_q <= tag_last_d;
    end
  end

endmodule

// File: tb/tb_dpram_burst_arbiter.sv
// Directed bench for dpram_burst_arbiter with a 2-cycle-latency RAM model.
// Cycle k=0 is the cycle a request is first presented in IDLE.
module tb_dpram_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [5:0] addr0, addr1;
  logic [1:0] len0, len1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, wbeat0, wbeat1, rvalid0, rvalid1, done0, done1, busy;
  logic [7:0] rdata;
  logic       mem_we;
  logic [5:0] mem_addr;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_burst_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .wbeat0(wbeat0), .wbeat1(wbeat1),
    .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .done0(done0), .done1(done1), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // RAM model: read data appears two cycles after the address.
  logic [7:0] ram [0:63];
  logic [7:0] rd1;
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    rd1      <= ram[mem_addr];
    mem_dout <= rd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
    len0 = 0; len1 = 0; wdata0 = 0; wdata1 = 0;
    step();
    step();
    #1;
    checks++;
    if ({gnt0, gnt1, wbeat0, wbeat1, rvalid0, rvalid1, done0, done1, busy, mem_we} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 0", {gnt0, gnt1, wbeat0, wbeat1, rvalid0, rvalid1, done0, done1, busy, mem_we});
    end
    checks++;
    if (mem_addr !== 6'd0 || mem_din !== 8'd0) begin
      errors++;
      $display("FAIL reset_mem addr %0d din %h want 0 0", mem_addr, mem_din);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    for (int k = 0; k <= 7; k++) begin
      step();
      req0 = (k <= 1); we0 = 1; addr0 = 6'd10; len0 = 2'd3;
      wdata0 = 8'hA1 + 8'(k - 2);
      #1;
      checks++;
      if (gnt0 !== (k == 1) || gnt1 !== 1'b0) begin
        errors++; $display("FAIL wr_gnt k=%0d gnt0 %b gnt1 %b", k, gnt0, gnt1);
      end
      checks++;
      if (mem_we !== (k >= 2 && k <= 5) || wbeat0 !== (k >= 2 && k <= 5)) begin
        errors++; $display("FAIL wr_we k=%0d mem_we %b wbeat0 %b", k, mem_we, wbeat0);
      end
      checks++;
      if (done0 !== (k == 6) || busy !== (k >= 1 && k <= 5)) begin
        errors++; $display("FAIL wr_done k=%0d done0 %b busy %b", k, done0, busy);
      end
      if (k >= 2 && k <= 5) begin
        checks++;
        if (mem_addr !== 6'(8 + k) || mem_din !== 8'(8'hA1 + 8'(k - 2))) begin
          errors++; $display("FAIL wr_beat k=%0d addr %0d din %h want %0d %h", k, mem_addr, mem_din, 8 + k, 8'hA1 + 8'(k - 2));
        end
      end
      if (k >= 6) begin
        checks++;
        if (mem_addr !== 6'd13) begin
          errors++; $display("FAIL wr_hold k=%0d addr %0d want 13", k, mem_addr);
        end
      end
    end
  endtask

  task automatic test_read();
    for (int k = 0; k <= 8; k++) begin
      step();
      req0 = (k <= 1); we0 = 0; addr0 = 6'd10; len0 = 2'd3;
      #1;
      checks++;
      if (rvalid0 !== (k >= 4 && k <= 7) || rvalid1 !== 1'b0 || mem_we !== 1'b0) begin
        errors++; $display("FAIL rd_vld k=%0d rvalid0 %b rvalid1 %b mem_we %b", k, rvalid0, rvalid1, mem_we);
      end
      checks++;
      if (done0 !== (k == 7)) begin
        errors++; $display("FAIL rd_done k=%0d done0 %b", k, done0);
      end
      if (k >= 4 && k <= 7) begin
        checks++;
        if (rdata !== 8'(8'hA1 + 8'(k - 4))) begin
          errors++; $display("FAIL rd_data k=%0d got %h want %h", k, rdata, 8'hA1 + 8'(k - 4));
        end
      end
    end
  endtask

  task automatic test_arb();
    rst_n = 1'b0;
    req0 = 0; req1 = 0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      step();
      req0 = (k <= 7); req1 = (k <= 7); we0 = 1; we1 = 1;
      len0 = 0; len1 = 0; addr0 = 6'd20; addr1 = 6'd30;
      wdata0 = 8'h55; wdata1 = 8'h66;
      #1;
      checks++;
      if (gnt0 !== (k == 1 || k == 7) || gnt1 !== (k == 4)) begin
        errors++; $display("FAIL arb_gnt k=%0d gnt0 %b gnt1 %b", k, gnt0, gnt1);
      end
      if (k == 5) begin
        checks++;
        if (mem_addr !== 6'd30 || mem_din !== 8'h66 || wbeat1 !== 1'b1 || wbeat0 !== 1'b0) begin
          errors++; $display("FAIL arb_beat1 addr %0d din %h wbeat %b%b", mem_addr, mem_din, wbeat1, wbeat0);
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k <= 7; k++) begin
      step();
      req1 = (k <= 1); we1 = 1; addr1 = 6'd62; len1 = 2'd3;
      wdata1 = 8'hB1 + 8'(k - 2);
      #1;
      checks++;
      if (gnt1 !== (k == 1) || gnt0 !== 1'b0) begin
        errors++; $display("FAIL wrap_gnt k=%0d gnt1 %b gnt0 %b", k, gnt1, gnt0);
      end
      checks++;
      if (wbeat1 !== (k >= 2 && k <= 5) || wbeat0 !== 1'b0 || done1 !== (k == 6)) begin
        errors++; $display("FAIL wrap_ctl k=%0d wbeat1 %b wbeat0 %b done1 %b", k, wbeat1, wbeat0, done1);
      end
      if (k >= 2 && k <= 5) begin
        checks++;
        if (mem_addr !== 6'(60 + k)) begin
          errors++; $display("FAIL wrap_addr k=%0d got %0d want %0d", k, mem_addr, 6'(60 + k));
        end
      end
    end
  endtask

  task automatic test_overlap();
    for (int k = 0; k <= 11; k++) begin
      step();
      req0 = (k <= 1); we0 = 0; addr0 = 6'd10; len0 = 2'd3;
      req1 = (k >= 2 && k <= 7); we1 = 1; addr1 = 6'd40; len1 = 2'd1;
      wdata1 = 8'hC1 + 8'(k - 8);
      #1;
      checks++;
      if (rvalid0 !== (k >= 4 && k <= 7) || rvalid1 !== 1'b0) begin
        errors++; $display("FAIL ovl_vld k=%0d rvalid0 %b rvalid1 %b", k, rvalid0, rvalid1);
      end
      checks++;
      if (gnt1 !== (k == 7) || done0 !== (k == 7) || done1 !== (k == 10)) begin
        errors++; $display("FAIL ovl_ctl k=%0d gnt1 %b done0 %b done1 %b", k, gnt1, done0, done1);
      end
      if (k >= 4 && k <= 7) begin
        checks++;
        if (rdata !== 8'(8'hA1 + 8'(k - 4))) begin
          errors++; $display("FAIL ovl_data k=%0d got %h want %h", k, rdata, 8'hA1 + 8'(k - 4));
        end
      end
      if (k == 8 || k == 9) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 6'(32 + k) || mem_din !== 8'(8'hC1 + 8'(k - 8))) begin
          errors++; $display("FAIL ovl_wr k=%0d we %b addr %0d din %h", k, mem_we, mem_addr, mem_din);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= 10; k++) begin
      step();
      rst_n = (k != 4);
      req0 = (k <= 1); req1 = 0; we0 = 0; addr0 = 6'd10; len0 = 2'd3;
      if (k >= 6) begin
        req0 = (k <= 7); req1 = (k <= 7); we0 = 1; we1 = 1;
        len0 = 0; len1 = 0; addr0 = 6'd50; addr1 = 6'd51;
      end
      #1;
      if (k == 4) begin
        checks++;
        if (rvalid0 !== 1'b1 || rdata !== 8'hA1 || mem_addr !== 6'd12) begin
          errors++; $display("FAIL rst_pre rvalid0 %b rdata %h addr %0d", rvalid0, rdata, mem_addr);
        end
      end
      if (k >= 5) begin
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || done0 !== (k == 9) || done1 !== 1'b0) begin
          errors++; $display("FAIL rst_flush k=%0d rvalid %b%b done %b%b", k, rvalid0, rvalid1, done0, done1);
        end
        checks++;
        if (busy !== (k == 7 || k == 8) || mem_we !== (k == 8)) begin
          errors++; $display("FAIL rst_busy k=%0d busy %b mem_we %b", k, busy, mem_we);
        end
        checks++;
        if (gnt0 !== (k == 7) || gnt1 !== 1'b0) begin
          errors++; $display("FAIL rst_gnt k=%0d gnt0 %b gnt1 %b", k, gnt0, gnt1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_arb();
    test_wrap();
    test_overlap();
    test_reset_mid();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
